codec_fir_sequencer: RTL and testbench

Sample-rate controller between the audio_codec read/write FIFO handshake and a single shared FIR filter engine. It pops one stereo sample from the codec and time-multiplexes the filter: left channel first, then right. It writes the filtered stereo pair back to the codec. A timeout guard prevents a hung filter from stalling the audio stream.

---
 rtl/codec_fir_sequencer_if.sv | 51 +++++
 rtl/codec_fir_sequencer.sv | 169 ++++++++++++++++
 tb/tb_codec_fir_sequencer.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/codec_fir_sequencer_if.sv
// Codec FIFO and FIR engine handshake bundle for codec_fir_sequencer.
// master = sequencer side; slave = codec and FIR engine side.
interface codec_fir_sequencer_if #(
    parameter int DW = 24
);
    logic          read_ready;
    logic [DW-1:0] readdata_left;
    logic [DW-1:0] readdata_right;
    logic          read;
    logic          write_ready;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    logic          fir_start;
    logic          fir_chan;
    logic [DW-1:0] fir_din;
    logic          fir_done;
    logic [DW-1:0] fir_dout;

    modport master (
        input  read_ready,
        input  readdata_left,
        input  readdata_right,
        output read,
        input  write_ready,
        output write,
        output writedata_left,
        output writedata_right,
        output fir_start,
        output fir_chan,
        output fir_din,
        input  fir_done,
        input  fir_dout
    );

    modport slave (
        output read_ready,
        output readdata_left,
        output readdata_right,
        input  read,
        output write_ready,
        input  write,
        input  writedata_left,
        input  writedata_right,
        input  fir_start,
        input  fir_chan,
        input  fir_din,
        output fir_done,
        output fir_dout
    );
endinterface

// File: rtl/codec_fir_sequencer.sv
// Pops a stereo sample from the codec, filters left then right on one
// shared FIR engine (with timeout fallback to raw), writes the pair back.
module codec_fir_sequencer #(
    parameter int DW      = 24,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    codec_fir_sequencer_if.master bus,
    input  logic                  bypass,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [CW-1:0]         sample_cnt
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        WAIT_L,
        WAIT_R,
        WR_WAIT,
        WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] raw_l_q, raw_l_d;
    logic [DW-1:0] raw_r_q, raw_r_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [DW-1:0] wd_l_q, wd_l_d;
    logic [DW-1:0] wd_r_q, wd_r_d;
    logic          start_q, start_d;
    logic          chan_q, chan_d;
    logic [DW-1:0] din_q, din_d;
    logic          busy_q, busy_d;
    logic          terr_q, terr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timer_hit;

    // The last wait cycle is the one where the timer reaches TIMEOUT at
    // the closing edge; a fir_done in that same cycle still wins.
    assign timer_hit = (timer_q == T_LAST);

    always_comb begin
        state_d = state_q;
        raw_l_d = raw_l_q;
        raw_r_d = raw_r_q;
        timer_d = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
        wd_l_d  = wd_l_q;
        wd_r_d  = wd_r_q;
        start_d = 1'b0;
        chan_d  = chan_q;
        din_d   = din_q;
        terr_d  = terr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.read_ready) begin
                    read_d  = 1'b1;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                raw_l_d = bus.readdata_left;
                raw_r_d = bus.readdata_right;
                if (bypass) begin
                    wd_l_d  = bus.readdata_left;
                    wd_r_d  = bus.readdata_right;
                    state_d = WR_WAIT;
                end else begin
                    din_d   = bus.readdata_left;
                    chan_d  = 1'b0;
                    start_d = 1'b1;
                    state_d = WAIT_L;
                end
            end
            WAIT_L: begin
                if (bus.fir_done || timer_hit) begin
                    wd_l_d  = bus.fir_done ? bus.fir_dout : raw_l_q;
                    terr_d  = terr_q | ~bus.fir_done;
                    din_d   = raw_r_q;
                    chan_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = WAIT_R;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_R: begin
                if (bus.fir_done || timer_hit) begin
                    wd_r_d  = bus.fir_done ? bus.fir_dout : raw_r_q;
                    terr_d  = terr_q | ~bus.fir_done;
                    state_d = WR_WAIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WR_WAIT: begin
                if (bus.write_ready) begin
                    write_d = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            raw_l_q <= '0;
            raw_r_q <= '0;
            timer_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wd_l_q  <= '0;
            wd_r_q  <= '0;
            start_q <= 1'b0;
            chan_q  <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            raw_l_q <= raw_l_d;
            raw_r_q <= raw_r_d;
            timer_q <= timer_d;
            read_q  <= read_d;
            write_q <= write_d;
            wd_l_q  <= wd_l_d;
            wd_r_q  <= wd_r_d;
            start_q <= start_d;
            chan_q  <= chan_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.read            = read_q;
    assign bus.write           = write_q;
    assign bus.writedata_left  = wd_l_q;
    assign bus.writedata_right = wd_r_q;
    assign bus.fir_start       = start_q;
    assign bus.fir_chan        = chan_q;
    assign bus.fir_din         = din_q;
    assign busy                = busy_q;
    assign timeout_err         = terr_q;
    assign sample_cnt          = cnt_q;

endmodule

// File: tb/tb_codec_fir_sequencer.sv
// Directed bench for codec_fir_sequencer with a latency-programmable
// FIR model (returns din+1) and pulse monitors on the codec strobes.
module tb_codec_fir_sequencer;

    localparam int DW = 24;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          bypass = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] sample_cnt;

    always #5 clk = ~clk;

    codec_fir_sequencer_if #(.DW(DW)) bus ();

    codec_fir_sequencer #(
        .DW(DW),
        .TIMEOUT(TO),
        .CW(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.master),
        .bypass(bypass),
        .busy(busy),
        .timeout_err(timeout_err),
        .sample_cnt(sample_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic          rd_rdy = 1'b0;
    logic [DW-1:0] rd_l = '0;
    logic [DW-1:0] rd_r = '0;
    logic          wr_rdy = 1'b0;
    logic          f_done = 1'b0;
    logic [DW-1:0] f_dout = '0;

    assign bus.read_ready     = rd_rdy;
    assign bus.readdata_left  = rd_l;
    assign bus.readdata_right = rd_r;
    assign bus.write_ready    = wr_rdy;
    assign bus.fir_done       = f_done;
    assign bus.fir_dout       = f_dout;

    // FIR model: result din+1 arrives fir_lat cycles after the start cycle
    bit            fir_en = 1'b1;
    int            fir_lat = 3;
    bit            fir_pend = 1'b0;
    int            fir_left = 0;
    logic [DW-1:0] fir_val = '0;

    always @(negedge clk) begin
        f_done = 1'b0;
        if (fir_pend) begin
            if (fir_left <= 1) begin
                f_done = 1'b1;
                f_dout = fir_val;
                fir_pend = 1'b0;
            end else begin
                fir_left--;
            end
        end
        if (bus.fir_start && fir_en) begin
            fir_pend = 1'b1;
            fir_left = fir_lat;
            fir_val  = bus.fir_din + DW'(1);
        end
    end

    int            cyc = 0;
    int            rd_tot = 0;
    int            wr_tot = 0;
    int            st_tot = 0;
    int            both_tot = 0;
    int            busy_tot = 0;
    int            rd_cyc = 0;
    int            st_cyc [64];
    logic          st_chan [64];
    logic [DW-1:0] st_din [64];

    always @(negedge clk) begin
        cyc++;
        if (bus.read) begin
            rd_tot++;
            rd_cyc = cyc;
        end
        if (bus.write) wr_tot++;
        if (bus.read && bus.write) both_tot++;
        if (busy) busy_tot++;
        if (bus.fir_start) begin
            st_cyc[st_tot % 64]  = cyc;
            st_chan[st_tot % 64] = bus.fir_chan;
            st_din[st_tot % 64]  = bus.fir_din;
            st_tot++;
        end
    end

    int rd_b, wr_b, st_b, busy_b;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mark();
        rd_b   = rd_tot;
        wr_b   = wr_tot;
        st_b   = st_tot;
        busy_b = busy_tot;
    endtask

    task automatic start_sample(input logic [DW-1:0] l,
                                input logic [DW-1:0] r,
                                input bit keep);
        int n;
        n = 0;
        tick();
        rd_l   = l;
        rd_r   = r;
        rd_rdy = 1'b1;
        do begin
            tick();
            n++;
        end while (!bus.read && n < 20);
        if (!bus.read) begin
            checks++;
            errors++;
            $display("FAIL read_timeout got no read want read within 20 cycles");
        end
        if (!keep) rd_rdy = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < budget);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got busy=1 want busy=0 within %0d", budget);
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.fir_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got rd=%b wr=%b st=%b want 0 0 0",
                     bus.read, bus.write, bus.fir_start);
        end
        checks++;
        if (bus.writedata_left !== '0 || bus.writedata_right !== '0 ||
            bus.fir_din !== '0 || bus.fir_chan !== 1'b0) begin
            errors++;
            $display("FAIL reset_data got l=%h r=%h din=%h ch=%b want 0",
                     bus.writedata_left, bus.writedata_right,
                     bus.fir_din, bus.fir_chan);
        end
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || sample_cnt !== '0) begin
            errors++;
            $display("FAIL reset_status got busy=%b terr=%b cnt=%0d want 0 0 0",
                     busy, timeout_err, sample_cnt);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        fir_en = 1'b1;
        fir_lat = 3;
        bypass = 1'b0;
        wr_rdy = 1'b1;
        mark();
        start_sample(24'h000100, 24'hFFFF00, 1'b0);
        wait_idle(100);
        checks++;
        if (rd_tot - rd_b != 1 || wr_tot - wr_b != 1) begin
            errors++;
            $display("FAIL normal_pulses got rd=%0d wr=%0d want 1 1",
                     rd_tot - rd_b, wr_tot - wr_b);
        end
        checks++;
        if (st_tot - st_b != 2 || st_chan[st_b % 64] !== 1'b0 ||
            st_chan[(st_b + 1) % 64] !== 1'b1) begin
            errors++;
            $display("FAIL normal_starts got n=%0d ch0=%b ch1=%b want 2 0 1",
                     st_tot - st_b, st_chan[st_b % 64],
                     st_chan[(st_b + 1) % 64]);
        end
        checks++;
        if (st_din[st_b % 64] !== 24'h000100 ||
            st_din[(st_b + 1) % 64] !== 24'hFFFF00) begin
            errors++;
            $display("FAIL normal_din got %h %h want 000100 ffff00",
                     st_din[st_b % 64], st_din[(st_b + 1) % 64]);
        end
        checks++;
        if (st_cyc[st_b % 64] - rd_cyc != 1) begin
            errors++;
            $display("FAIL read_to_start got %0d want 1",
                     st_cyc[st_b % 64] - rd_cyc);
        end
        checks++;
        if (bus.writedata_left !== 24'h000101 ||
            bus.writedata_right !== 24'hFFFF01) begin
            errors++;
            $display("FAIL normal_data got %h %h want 000101 ffff01",
                     bus.writedata_left, bus.writedata_right);
        end
        checks++;
        if (sample_cnt !== 4'd1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL normal_status got cnt=%0d terr=%b want 1 0",
                     sample_cnt, timeout_err);
        end
    endtask

    task automatic test_min_latency();
        fir_lat = 1;
        mark();
        start_sample(24'h7FFFFF, 24'hFFFFFF, 1'b0);
        wait_idle(100);
        checks++;
        if (busy_tot - busy_b != 7) begin
            errors++;
            $display("FAIL min_latency got %0d want 7", busy_tot - busy_b);
        end
        checks++;
        if (bus.writedata_left !== 24'h800000 ||
            bus.writedata_right !== 24'h000000 || sample_cnt !== 4'd2) begin
            errors++;
            $display("FAIL min_data got %h %h cnt=%0d want 800000 000000 2",
                     bus.writedata_left, bus.writedata_right, sample_cnt);
        end
        fir_lat = 3;
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        mark();
        start_sample(24'h123456, 24'h654321, 1'b0);
        wait_idle(100);
        checks++;
        if (st_tot - st_b != 0 || busy_tot - busy_b != 3) begin
            errors++;
            $display("FAIL bypass_path got starts=%0d busy=%0d want 0 3",
                     st_tot - st_b, busy_tot - busy_b);
        end
        checks++;
        if (bus.writedata_left !== 24'h123456 ||
            bus.writedata_right !== 24'h654321 ||
            sample_cnt !== 4'd3 || wr_tot - wr_b != 1) begin
            errors++;
            $display("FAIL bypass_data got %h %h cnt=%0d want 123456 654321 3",
                     bus.writedata_left, bus.writedata_right, sample_cnt);
        end
        bypass = 1'b0;
        mark();
        start_sample(24'h000020, 24'h000030, 1'b0);
        tick();
        bypass = 1'b1;
        wait_idle(100);
        bypass = 1'b0;
        checks++;
        if (st_tot - st_b != 2 || bus.writedata_left !== 24'h000021 ||
            bus.writedata_right !== 24'h000031 || sample_cnt !== 4'd4) begin
            errors++;
            $display("FAIL bypass_inflight got st=%0d %h %h cnt=%0d want 2 000021 000031 4",
                     st_tot - st_b, bus.writedata_left,
                     bus.writedata_right, sample_cnt);
        end
    endtask

    task automatic test_done_at_limit();
        fir_lat = TO - 1;
        mark();
        start_sample(24'h000040, 24'h000050, 1'b0);
        wait_idle(100);
        checks++;
        if (st_cyc[(st_b + 1) % 64] - st_cyc[st_b % 64] != TO) begin
            errors++;
            $display("FAIL limit_wait got %0d want %0d",
                     st_cyc[(st_b + 1) % 64] - st_cyc[st_b % 64], TO);
        end
        checks++;
        if (bus.writedata_left !== 24'h000041 ||
            bus.writedata_right !== 24'h000051 ||
            timeout_err !== 1'b0 || sample_cnt !== 4'd5) begin
            errors++;
            $display("FAIL limit_done got %h %h terr=%b cnt=%0d want 000041 000051 0 5",
                     bus.writedata_left, bus.writedata_right,
                     timeout_err, sample_cnt);
        end
        fir_lat = 3;
    endtask

    task automatic test_timeout();
        fir_en = 1'b0;
        mark();
        start_sample(24'h0000AA, 24'h0000BB, 1'b0);
        wait_idle(100);
        checks++;
        if (st_cyc[(st_b + 1) % 64] - st_cyc[st_b % 64] != TO ||
            busy_tot - busy_b != 2 * TO + 3) begin
            errors++;
            $display("FAIL timeout_wait got gap=%0d busy=%0d want %0d %0d",
                     st_cyc[(st_b + 1) % 64] - st_cyc[st_b % 64],
                     busy_tot - busy_b, TO, 2 * TO + 3);
        end
        checks++;
        if (bus.writedata_left !== 24'h0000AA ||
            bus.writedata_right !== 24'h0000BB ||
            timeout_err !== 1'b1 || sample_cnt !== 4'd6) begin
            errors++;
            $display("FAIL timeout_data got %h %h terr=%b cnt=%0d want 0000aa 0000bb 1 6",
                     bus.writedata_left, bus.writedata_right,
                     timeout_err, sample_cnt);
        end
        fir_en = 1'b1;
        start_sample(24'h000001, 24'h000002, 1'b0);
        wait_idle(100);
        checks++;
        if (bus.writedata_left !== 24'h000002 ||
            bus.writedata_right !== 24'h000003 ||
            timeout_err !== 1'b1 || sample_cnt !== 4'd7) begin
            errors++;
            $display("FAIL timeout_sticky got %h %h terr=%b cnt=%0d want 000002 000003 1 7",
                     bus.writedata_left, bus.writedata_right,
                     timeout_err, sample_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] snap_l, snap_r;
        wr_rdy = 1'b0;
        mark();
        start_sample(24'h00ABCD, 24'h00DCBA, 1'b1);
        repeat (20) tick();
        snap_l = bus.writedata_left;
        snap_r = bus.writedata_right;
        repeat (30) tick();
        checks++;
        if (busy !== 1'b1 || rd_tot - rd_b != 1 || wr_tot - wr_b != 0) begin
            errors++;
            $display("FAIL bp_hold got busy=%b rd=%0d wr=%0d want 1 1 0",
                     busy, rd_tot - rd_b, wr_tot - wr_b);
        end
        checks++;
        if (bus.writedata_left !== 24'h00ABCE ||
            bus.writedata_right !== 24'h00DCBB ||
            snap_l !== 24'h00ABCE || snap_r !== 24'h00DCBB) begin
            errors++;
            $display("FAIL bp_stable got %h %h (at 20: %h %h) want 00abce 00dcbb",
                     bus.writedata_left, bus.writedata_right, snap_l, snap_r);
        end
        rd_rdy = 1'b0;
        wr_rdy = 1'b1;
        wait_idle(20);
        checks++;
        if (wr_tot - wr_b != 1 || rd_tot - rd_b != 1 || sample_cnt !== 4'd8) begin
            errors++;
            $display("FAIL bp_release got wr=%0d rd=%0d cnt=%0d want 1 1 8",
                     wr_tot - wr_b, rd_tot - rd_b, sample_cnt);
        end
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        mark();
        start_sample(24'h000011, 24'h000022, 1'b0);
        while (st_tot - st_b < 2 && n < 30) begin
            tick();
            n++;
        end
        if (st_tot - st_b < 2) begin
            checks++;
            errors++;
            $display("FAIL ar_reach got starts=%0d want 2", st_tot - st_b);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.fir_start !== 1'b0 || bus.fir_chan !== 1'b0 ||
            bus.fir_din !== '0 || bus.writedata_left !== '0) begin
            errors++;
            $display("FAIL ar_outputs got busy=%b st=%b ch=%b din=%h l=%h want 0",
                     busy, bus.fir_start, bus.fir_chan,
                     bus.fir_din, bus.writedata_left);
        end
        checks++;
        if (sample_cnt !== '0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL ar_status got cnt=%0d terr=%b want 0 0",
                     sample_cnt, timeout_err);
        end
        tick();
        tick();
        reset_n = 1'b1;
        mark();
        repeat (20) tick();
        checks++;
        if (wr_tot - wr_b != 0 || rd_tot - rd_b != 0) begin
            errors++;
            $display("FAIL ar_no_write got wr=%0d rd=%0d want 0 0",
                     wr_tot - wr_b, rd_tot - rd_b);
        end
        start_sample(24'h000005, 24'h000006, 1'b0);
        wait_idle(100);
        checks++;
        if (bus.writedata_left !== 24'h000006 ||
            bus.writedata_right !== 24'h000007 ||
            sample_cnt !== 4'd1 || wr_tot - wr_b != 1) begin
            errors++;
            $display("FAIL ar_fresh got %h %h cnt=%0d wr=%0d want 000006 000007 1 1",
                     bus.writedata_left, bus.writedata_right,
                     sample_cnt, wr_tot - wr_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] e;
        int n;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        fir_lat = 1;
        wr_rdy = 1'b1;
        bypass = 1'b0;
        rd_l = 24'h000010;
        rd_r = 24'h000020;
        mark();
        rd_rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (rd_tot - rd_b >= 17) rd_rdy = 1'b0;
            end while (!bus.write && n < 40);
            tick();
            if (rd_tot - rd_b >= 17) rd_rdy = 1'b0;
            e = CW'(i + 1);
            checks++;
            if (!(n < 40 || bus.write) || sample_cnt !== e) begin
                errors++;
                $display("FAIL wrap_cnt_%0d got %0d want %0d", i, sample_cnt, e);
            end
        end
        rd_rdy = 1'b0;
        wait_idle(40);
        checks++;
        if (wr_tot - wr_b != 17 || rd_tot - rd_b != 17) begin
            errors++;
            $display("FAIL wrap_pulses got wr=%0d rd=%0d want 17 17",
                     wr_tot - wr_b, rd_tot - rd_b);
        end
        checks++;
        if (both_tot != 0) begin
            errors++;
            $display("FAIL rd_wr_overlap got %0d want 0", both_tot);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_min_latency();
        test_bypass();
        test_done_at_limit();
        test_timeout();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
